clk_tick_gen: RTL and testbench
===============================

// Module: clk_tick_gen
// PURPOSE
//   Multi-channel programmable clock-enable generator; next generation of the
//   power-of-2 ripple divider. Per channel: runtime divisor, 1-cycle TICK
//   enable pulse and divided square wave, all in the CLK_in domain (no derived
//   clocks). Feeds display refresh, debouncers and sequencer step enables.
// PARAMETERS
//   NCH      4    number of independent channels
//   DIV_W    16   divisor width per channel (max period 2^DIV_W-1 cycles)
//   DEF_DIV  2    divisor loaded into every channel at reset (DEF_DIV < 2^DIV_W)
// PORTS
//   CLK_in        in   1          system clock; single clock domain
//   RSTn_in       in   1          reset, asynchronous, active-low
//   EN_in         in   NCH        per-channel run enable
//   DIV_in        in   NCH*DIV_W  divisor, channel i = DIV_in[i*DIV_W +: DIV_W]
//   LOAD_in       in   NCH        per-channel divisor load request
//   LOAD_ACK_out  out  NCH        1-cycle pulse: new divisor now active
//   TICK_out      out  NCH        1-cycle enable pulse, once per period
//   SQW_out       out  NCH        toggles on each tick (period 2*D cycles)
//   SYNC_in       in   1          only with CLKDIV_SYNC_EN
// BEHAVIOUR
//   Reset (RSTn_in low, async): cnt=0, div_act=DEF_DIV, pend=0, TICK_out=0,
//     SQW_out=0, LOAD_ACK_out=0 on all channels. Deassertion takes effect at
//     the next CLK_in edge.
//   Per-channel state: cnt[DIV_W], div_act[DIV_W], div_pend[DIV_W], pend flag.
//   Effective period P = (div_act<=1) ? 1 : div_act. Divisor 0 behaves as 1.
//   Run (EN_in[i]=1), each edge:
//     - wrap = (cnt >= P-1). wrap: cnt<=0, TICK<=1, SQW<=~SQW.
//       else cnt<=cnt+1, TICK<=0.
//     - First tick: TICK_out high after edge P, counting from the first edge
//       with EN high, then every P edges. D=1 gives SQW = CLK_in/2.
//   Hold (EN_in[i]=0): cnt and SQW hold, TICK<=0. A pending load applies at
//     the next edge. Re-enable resumes from the held cnt.
//   Load handshake:
//     - LOAD_in[i] high at an edge: div_pend<=DIV_in slice, pend<=1. Level or
//       pulse both accepted. Sampled every high cycle; last value wins.
//     - Apply point: edge where pend=1 AND (wrap OR EN low), using the pend
//       value registered before that edge. div_act<=div_pend, pend<=0,
//       cnt<=0, LOAD_ACK_out[i]<=1 for exactly one cycle.
//     - LOAD_in high on the apply edge: the new capture re-arms pend. The
//       current apply still happens and acks. The new value applies at the
//       following boundary with a second ack.
//     - LOAD at a wrap edge with pend=0: captured only, applied next boundary.
//     - A running period is never truncated. Periods are always whole.
//   Channels are fully independent. No cross-channel state.
//   Out-of-range: none. All DIV_W-bit values are legal; cnt never exceeds P-1.
//     On apply, cnt is cleared, so a smaller divisor cannot overshoot.
//   Reset mid-operation: immediate async clear; pending loads are discarded
//     with no ack.
// CONFIGURATION
//   CLKDIV_SYNC_EN defined: adds SYNC_in.
//     - SYNC_in high at an edge: every channel gets cnt<=0, SQW<=0, TICK<=0.
//     - Any pend applies immediately with its ack.
//     - SYNC has priority over wrap and EN. Channels restart phase-aligned.
//     - LOAD captured on a SYNC edge is treated as pend for the next boundary.
//   CLKDIV_SYNC_EN undefined: SYNC_in port absent; no alignment logic.
// TESTING
//   1 Reset release, EN=1 all, DEF_DIV=2 -> TICK every 2 cycles, first after
//     edge 2; SQW period 4; ACK stays 0.
//   2 Ch0 running D=5, LOAD D=3 at cnt=1 -> ACK at the wrap edge after 5-cycle
//     period completes; next ticks every 3 cycles.
//   3 D=0 and D=1 loaded (EN=0, immediate apply) -> TICK constantly high when
//     enabled; SQW toggles every cycle; ACK 1 cycle after each load.
//   4 D=0xFFFF with EN toggled off 10 cycles mid-period -> tick spacing
//     65535 + 10; TICK never high while EN=0.
//   5 LOAD 7 then LOAD 9 back-to-back before the boundary -> single ACK,
//     period 9. RSTn_in pulsed mid-period with pend=1 -> all outputs 0, no ACK,
//     DEF_DIV restored.
//   6 (CLKDIV_SYNC_EN) ch D=3,4,6 free-running, SYNC pulse -> all SQW=0, and
//     TICKs coincide again after 12 cycles.

Source files
------------

// File: rtl/clk_tick_gen_if.sv
// clk_tick_gen_if: per-channel enable, divisor load and tick/square-wave bus for clk_tick_gen
interface clk_tick_gen_if #(
  parameter int NCH   = 4,
  parameter int DIV_W = 16
);
  logic [NCH-1:0]       en, load, load_ack, tick, sqw;
  logic [NCH*DIV_W-1:0] div;
  modport master (output en, div, load, input load_ack, tick, sqw);
  modport slave (input en, div, load, output load_ack, tick, sqw);
endinterface

// File: rtl/clk_tick_gen.sv
// clk_tick_gen: multi-channel programmable clock-enable generator; CLKDIV_SYNC_EN adds SYNC_in phase alignment
module clk_tick_gen #(
  parameter int NCH     = 4,
  parameter int DIV_W   = 16,
  parameter int DEF_DIV = 2
) (
  input logic CLK_in,
  input logic RSTn_in,
`ifdef CLKDIV_SYNC_EN
  input logic SYNC_in,
`endif
  clk_tick_gen_if.slave bus
);
  logic sync;
`ifdef CLKDIV_SYNC_EN
  assign sync = SYNC_in;
`else
  assign sync = 1'b0;
`endif
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [DIV_W-1:0] cnt, div_act, div_pend, last;
    logic pend, tick, sqw, ack, en, wrap, apply;
    assign en    = bus.en[g];
    assign last  = (div_act <= DIV_W'(1)) ? '0 : div_act - DIV_W'(1);
    assign wrap  = cnt >= last;
    assign apply = pend & (sync | wrap | ~en);
    // period counter, tick/square outputs and divisor load handshake
    always_ff @(posedge CLK_in or negedge RSTn_in)
      if (!RSTn_in) begin
        cnt      <= '0;
        div_act  <= DIV_W'(DEF_DIV);
        div_pend <= '0;
        pend     <= 1'b0;
        tick     <= 1'b0;
        sqw      <= 1'b0;
        ack      <= 1'b0;
      end else begin
        tick <= ~sync & en & wrap;
        sqw  <= sync ? 1'b0 : sqw ^ (en & wrap);
        cnt  <= (sync | apply | (en & wrap)) ? '0 : cnt + DIV_W'(en);
        ack  <= apply;
        if (apply) div_act <= div_pend;
        if (bus.load[g]) div_pend <= bus.div[g*DIV_W +: DIV_W];
        pend <= bus.load[g] | (pend & ~apply);
      end
    assign bus.tick[g]     = tick;
    assign bus.sqw[g]      = sqw;
    assign bus.load_ack[g] = ack;
  end
endmodule

// File: tb/tb_clk_tick_gen.sv
// tb_clk_tick_gen: directed and randomized checks of clk_tick_gen (CLKDIV_SYNC_EN adds the sync scenario)
module tb_clk_tick_gen;
  localparam int N = 4, W = 10, DMAX = (1 << W) - 1;
  logic clk = 1'b0, rst_n = 1'b1;
`ifdef CLKDIV_SYNC_EN
  logic sync = 1'b0;
`endif
  int total = 0, bad = 0;
  clk_tick_gen_if #(.NCH(N), .DIV_W(W)) bus ();
  clk_tick_gen #(.NCH(N), .DIV_W(W), .DEF_DIV(2)) dut (
    .CLK_in(clk),
    .RSTn_in(rst_n),
`ifdef CLKDIV_SYNC_EN
    .SYNC_in(sync),
`endif
    .bus(bus)
  );
  always #5 clk = ~clk;

  // reference model: remaining edges until the next tick, per channel
  int m_r[N], m_act[N], m_pv[N];
  bit m_pend[N];
  logic [N-1:0] m_tick, m_sqw, m_ack;

  function automatic int per(int d);
    return d <= 1 ? 1 : d;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_act[i] = 2; m_r[i] = 2; m_pend[i] = 0; m_pv[i] = 0;
    end
    m_tick = '0; m_sqw = '0; m_ack = '0;
  endtask

  task automatic model_step();
    bit s;
    s = 0;
`ifdef CLKDIV_SYNC_EN
    s = sync;
`endif
    for (int i = 0; i < N; i++) begin
      int p, nr;
      bit e, wr, ap, nt;
      p  = per(m_act[i]);
      e  = bus.en[i];
      wr = (m_r[i] == 1);
      ap = m_pend[i] && (s || !e || wr);
      nt = !s && e && wr;
      m_tick[i] = nt;
      m_sqw[i]  = s ? 1'b0 : m_sqw[i] ^ nt;
      nr = (s || (e && wr)) ? p : (e ? m_r[i] - 1 : m_r[i]);
      if (ap) begin
        m_act[i] = m_pv[i];
        nr = per(m_pv[i]);
        m_pend[i] = 0;
      end
      m_r[i]   = nr;
      m_ack[i] = ap;
      if (bus.load[i]) begin
        m_pend[i] = 1;
        m_pv[i] = int'(bus.div[i*W +: W]);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic set_div(input int ch, input int v);
    bus.div[ch*W +: W] = W'(v);
  endtask

  task automatic clear_inputs();
    bus.en = '0; bus.load = '0; bus.div = '0;
`ifdef CLKDIV_SYNC_EN
    sync = 1'b0;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    #2 rst_n = 1'b0;
    model_reset();
    #10;
    total += 3;
    if (bus.tick !== 4'h0) begin bad++; $display("FAIL reset_tick: got %h want 0", bus.tick); end
    if (bus.sqw !== 4'h0) begin bad++; $display("FAIL reset_sqw: got %h want 0", bus.sqw); end
    if (bus.load_ack !== 4'h0) begin bad++; $display("FAIL reset_ack: got %h want 0", bus.load_ack); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.en = 4'hF;
    cyc(); cyc();
    total++;
    if (bus.sqw !== 4'hF) begin bad++; $display("FAIL pre_async_sqw: got %h want f", bus.sqw); end
    #2 rst_n = 1'b0;
    #1;
    total += 3;
    if (bus.tick !== 4'h0) begin bad++; $display("FAIL async_tick: got %h want 0", bus.tick); end
    if (bus.sqw !== 4'h0) begin bad++; $display("FAIL async_sqw: got %h want 0", bus.sqw); end
    if (bus.load_ack !== 4'h0) begin bad++; $display("FAIL async_ack: got %h want 0", bus.load_ack); end
  endtask

  task automatic test_default();
    do_reset();
    bus.en = 4'hF;
    for (int k = 1; k <= 12; k++) begin
      logic [3:0] et, es;
      cyc();
      et = (k % 2 == 0) ? 4'hF : 4'h0;
      es = ((k / 2) % 2 == 1) ? 4'hF : 4'h0;
      total += 3;
      if (bus.tick !== et) begin bad++; $display("FAIL def_tick e%0d: got %h want %h", k, bus.tick, et); end
      if (bus.sqw !== es) begin bad++; $display("FAIL def_sqw e%0d: got %h want %h", k, bus.sqw, es); end
      if (bus.load_ack !== 4'h0) begin bad++; $display("FAIL def_ack e%0d: got %h want 0", k, bus.load_ack); end
    end
  endtask

  task automatic test_load_wrap();
    do_reset();
    set_div(0, 5); bus.load = 4'b0001;
    cyc();
    bus.load = 4'b0000;
    cyc();
    total++;
    if (bus.load_ack !== 4'b0001) begin bad++; $display("FAIL lw_hold_ack: got %h want 1", bus.load_ack); end
    bus.en = 4'b0001;
    set_div(0, 3);
    for (int k = 1; k <= 14; k++) begin
      logic [3:0] et, ea;
      bus.load = (k == 2) ? 4'b0001 : 4'b0000;
      cyc();
      et = (k == 5 || k == 8 || k == 11 || k == 14) ? 4'b0001 : 4'b0000;
      ea = (k == 5) ? 4'b0001 : 4'b0000;
      total += 2;
      if (bus.tick !== et) begin bad++; $display("FAIL lw_tick e%0d: got %h want %h", k, bus.tick, et); end
      if (bus.load_ack !== ea) begin bad++; $display("FAIL lw_ack e%0d: got %h want %h", k, bus.load_ack, ea); end
    end
  endtask

  task automatic test_div01();
    do_reset();
    set_div(0, 0); set_div(1, 1); set_div(2, 0); set_div(3, 1);
    bus.load = 4'hF;
    cyc();
    bus.load = 4'h0;
    total++;
    if (bus.load_ack !== 4'h0) begin bad++; $display("FAIL d01_early_ack: got %h want 0", bus.load_ack); end
    cyc();
    total++;
    if (bus.load_ack !== 4'hF) begin bad++; $display("FAIL d01_ack: got %h want f", bus.load_ack); end
    bus.en = 4'hF;
    for (int k = 1; k <= 6; k++) begin
      logic [3:0] es;
      cyc();
      es = (k % 2 == 1) ? 4'hF : 4'h0;
      total += 3;
      if (bus.tick !== 4'hF) begin bad++; $display("FAIL d01_tick e%0d: got %h want f", k, bus.tick); end
      if (bus.sqw !== es) begin bad++; $display("FAIL d01_sqw e%0d: got %h want %h", k, bus.sqw, es); end
      if (bus.load_ack !== 4'h0) begin bad++; $display("FAIL d01_ack2 e%0d: got %h want 0", k, bus.load_ack); end
    end
  endtask

  task automatic test_max();
    int t, early, first, second;
    t = 0; early = 0; first = 0; second = 0;
    do_reset();
    set_div(0, DMAX); bus.load = 4'b0001;
    cyc();
    bus.load = 4'b0000;
    cyc();
    bus.en = 4'b0001;
    repeat (500) begin cyc(); t++; if (bus.tick !== 4'h0) early++; end
    bus.en = 4'b0000;
    repeat (10) begin cyc(); t++; if (bus.tick !== 4'h0) early++; end
    bus.en = 4'b0001;
    while (first == 0 && t < 3000) begin cyc(); t++; if (bus.tick[0]) first = t; end
    t = 0;
    while (second == 0 && t < 3000) begin cyc(); t++; if (bus.tick[0]) second = t; end
    total += 3;
    if (early !== 0) begin bad++; $display("FAIL max_early_ticks: got %0d want 0", early); end
    if (first !== DMAX + 10) begin bad++; $display("FAIL max_first_gap: got %0d want %0d", first, DMAX + 10); end
    if (second !== DMAX) begin bad++; $display("FAIL max_second_gap: got %0d want %0d", second, DMAX); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_div(0, 4); bus.load = 4'b0001;
    cyc();
    bus.load = 4'b0000;
    cyc();
    bus.en = 4'b0001;
    for (int k = 1; k <= 22; k++) begin
      logic [3:0] et, ea;
      bus.load = (k <= 2) ? 4'b0001 : 4'b0000;
      set_div(0, (k == 1) ? 7 : 9);
      cyc();
      et = (k == 4 || k == 13 || k == 22) ? 4'b0001 : 4'b0000;
      ea = (k == 4) ? 4'b0001 : 4'b0000;
      total += 2;
      if (bus.tick !== et) begin bad++; $display("FAIL b2b_tick e%0d: got %h want %h", k, bus.tick, et); end
      if (bus.load_ack !== ea) begin bad++; $display("FAIL b2b_ack e%0d: got %h want %h", k, bus.load_ack, ea); end
    end
    set_div(0, 5); bus.load = 4'b0001;
    cyc();
    bus.load = 4'b0000;
    cyc();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    total += 3;
    if (bus.tick !== 4'h0) begin bad++; $display("FAIL b2b_rst_tick: got %h want 0", bus.tick); end
    if (bus.sqw !== 4'h0) begin bad++; $display("FAIL b2b_rst_sqw: got %h want 0", bus.sqw); end
    if (bus.load_ack !== 4'h0) begin bad++; $display("FAIL b2b_rst_ack: got %h want 0", bus.load_ack); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.en = 4'hF;
    for (int k = 1; k <= 6; k++) begin
      logic [3:0] et;
      cyc();
      et = (k % 2 == 0) ? 4'hF : 4'h0;
      total += 2;
      if (bus.tick !== et) begin bad++; $display("FAIL b2b_def_tick e%0d: got %h want %h", k, bus.tick, et); end
      if (bus.load_ack !== 4'h0) begin bad++; $display("FAIL b2b_no_ack e%0d: got %h want 0", k, bus.load_ack); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < N; i++) begin
        bus.en[i]   = ($urandom_range(0, 3) != 0);
        bus.load[i] = ($urandom_range(0, 7) == 0);
        set_div(i, $urandom_range(0, 7));
      end
`ifdef CLKDIV_SYNC_EN
      sync = ($urandom_range(0, 40) == 0);
`endif
      cyc();
      total += 3;
      if (bus.tick !== m_tick) begin bad++; $display("FAIL rnd_tick c%0d: got %h want %h", n, bus.tick, m_tick); end
      if (bus.sqw !== m_sqw) begin bad++; $display("FAIL rnd_sqw c%0d: got %h want %h", n, bus.sqw, m_sqw); end
      if (bus.load_ack !== m_ack) begin bad++; $display("FAIL rnd_ack c%0d: got %h want %h", n, bus.load_ack, m_ack); end
    end
    clear_inputs();
  endtask

`ifdef CLKDIV_SYNC_EN
  task automatic test_sync();
    int early;
    early = 0;
    do_reset();
    set_div(0, 3); set_div(1, 4); set_div(2, 6);
    bus.load = 4'b0111;
    cyc();
    bus.load = 4'b0000;
    cyc();
    bus.en = 4'hF;
    repeat (17) cyc();
    set_div(3, 5); bus.load = 4'b1000;
    cyc();
    bus.load = 4'b0000;
    sync = 1'b1;
    cyc();
    sync = 1'b0;
    total += 3;
    if (bus.sqw !== 4'h0) begin bad++; $display("FAIL sync_sqw: got %h want 0", bus.sqw); end
    if (bus.tick !== 4'h0) begin bad++; $display("FAIL sync_tick: got %h want 0", bus.tick); end
    if (bus.load_ack !== 4'b1000) begin bad++; $display("FAIL sync_ack: got %h want 8", bus.load_ack); end
    for (int k = 1; k < 12; k++) begin
      cyc();
      if (bus.tick[2:0] === 3'b111) early++;
    end
    cyc();
    total += 2;
    if (early !== 0) begin bad++; $display("FAIL sync_early_align: got %0d want 0", early); end
    if (bus.tick[2:0] !== 3'b111) begin bad++; $display("FAIL sync_align12: got %b want 111", bus.tick[2:0]); end
  endtask
`endif

  initial begin
    test_reset();
    test_default();
    test_load_wrap();
    test_div01();
    test_max();
    test_back_to_back();
    test_random();
`ifdef CLKDIV_SYNC_EN
    test_sync();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
